// File: rtl/tpu_image_loader.sv
// Assembles a 32x32 1-bit image from a 128-byte UART stream and sequences the TPU.
// Optional trailing XOR checksum byte: define TPU_IMG_CHECKSUM_EN.
module tpu_image_loader #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TPU_MAX_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          iRst_n,
  input  logic          clear,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tpu_done,
  input  logic [3:0]    tpu_num,
  output logic [1023:0] image_out,
  output logic          tpu_ena,
  output logic          busy,
  output logic [3:0]    result,
  output logic          result_valid,
  output logic          err_timeout,
`ifdef TPU_IMG_CHECKSUM_EN
  output logic          err_checksum,
`endif
  output logic          err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W  = $clog2(TPU_MAX_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(TPU_MAX_CYCLES);

`ifdef TPU_IMG_CHECKSUM_EN
  localparam logic [7:0] LAST_BYTE = 8'd128;

  function automatic logic [7:0] csum_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  localparam logic [7:0] LAST_BYTE = 8'd127;
`endif

  state_t           state_q, state_d;
  logic [1023:0]    image_q, image_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
  logic             tpu_ena_q, tpu_ena_d;
  logic             busy_q, busy_d;
  logic [3:0]       result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overrun_q, err_overrun_d;
`ifdef TPU_IMG_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             err_checksum_q, err_checksum_d;
`endif

  // Saturating increments so neither counter can wrap.
  assign gap_inc = (gap_q == GAP_LIM) ? gap_q : (gap_q + GAP_W'(1));
  assign wd_inc  = (wd_q == WD_LIM) ? wd_q : (wd_q + WD_W'(1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    image_d        = image_q;
    byte_cnt_d     = byte_cnt_q;
    gap_d          = gap_q;
    wd_d           = wd_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_timeout_d  = 1'b0;
    err_overrun_d  = err_overrun_q;
`ifdef TPU_IMG_CHECKSUM_EN
    csum_d         = csum_q;
    err_checksum_d = 1'b0;
`endif

    if (clear) begin
      state_d        = S_IDLE;
      image_d        = '0;
      byte_cnt_d     = 8'd0;
      gap_d          = '0;
      wd_d           = '0;
      result_valid_d = 1'b0;
      err_overrun_d  = 1'b0;
`ifdef TPU_IMG_CHECKSUM_EN
      csum_d         = 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (rx_valid) begin
            state_d        = S_LOAD;
            image_d        = {1016'd0, rx_data};
            byte_cnt_d     = 8'd1;
            gap_d          = '0;
            result_valid_d = 1'b0;
            err_overrun_d  = 1'b0;
`ifdef TPU_IMG_CHECKSUM_EN
            csum_d         = rx_data;
`endif
          end else begin
            state_d = state_q;
          end
        end

        S_LOAD: begin
          if (rx_valid) begin
            gap_d = '0;
            if (byte_cnt_q < 8'd128) begin
              image_d[{byte_cnt_q[6:0], 3'b000} +: 8] = rx_data;
`ifdef TPU_IMG_CHECKSUM_EN
              csum_d = csum_acc(csum_q, rx_data);
`endif
            end else begin
              image_d = image_q;
            end

            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = 8'd0;
              wd_d       = '0;
`ifdef TPU_IMG_CHECKSUM_EN
              // The checksum byte itself is never stored in the image.
              if (rx_data == csum_q) begin
                state_d = S_RUN;
              end else begin
                state_d        = S_IDLE;
                err_checksum_d = 1'b1;
                result_valid_d = 1'b0;
              end
`else
              state_d = S_RUN;
`endif
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end else if (gap_inc == GAP_LIM) begin
            // Partial image is left in place; only the sequencing is reset.
            err_timeout_d = 1'b1;
            byte_cnt_d    = 8'd0;
            gap_d         = '0;
            state_d       = S_IDLE;
          end else begin
            gap_d = gap_inc;
          end
        end

        S_RUN: begin
          if (rx_valid) begin
            err_overrun_d = 1'b1;
          end else begin
            err_overrun_d = err_overrun_q;
          end

          if (tpu_done) begin
            result_d       = tpu_num;
            result_valid_d = 1'b1;
            wd_d           = '0;
            state_d        = S_DONE;
          end else if (wd_inc == WD_LIM) begin
            err_timeout_d  = 1'b1;
            result_valid_d = 1'b0;
            wd_d           = '0;
            state_d        = S_IDLE;
          end else begin
            wd_d = wd_inc;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    tpu_ena_d = (state_d == S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q        <= S_IDLE;
      image_q        <= '0;
      byte_cnt_q     <= 8'd0;
      gap_q          <= '0;
      wd_q           <= '0;
      tpu_ena_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= 4'd0;
      result_valid_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overrun_q  <= 1'b0;
`ifdef TPU_IMG_CHECKSUM_EN
      csum_q         <= 8'd0;
      err_checksum_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      image_q        <= image_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_q          <= gap_d;
      wd_q           <= wd_d;
      tpu_ena_q      <= tpu_ena_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_timeout_q  <= err_timeout_d;
      err_overrun_q  <= err_overrun_d;
`ifdef TPU_IMG_CHECKSUM_EN
      csum_q         <= csum_d;
      err_checksum_q <= err_checksum_d;
`endif
    end
  end

  assign image_out    = image_q;
  assign tpu_ena      = tpu_ena_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err_timeout  = err_timeout_q;
  assign err_overrun  = err_overrun_q;
`ifdef TPU_IMG_CHECKSUM_EN
  assign err_checksum = err_checksum_q;
`endif

endmodule

// File: tb/tb_tpu_image_loader.sv
// Self-checking bench for tpu_image_loader: scenario table, random images against a
// byte-array reference, and hand-written clear / reset / checksum sequences.
`timescale 1ns/1ps
module tb_tpu_image_loader;
  localparam int TO = 100;
  localparam int WD = 200;

  logic          clk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          clear = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          tpu_done = 1'b0;
  logic [3:0]    tpu_num = 4'd0;
  logic [1023:0] image_out;
  logic          tpu_ena, busy, result_valid, err_timeout, err_overrun;
  logic [3:0]    result;
`ifdef TPU_IMG_CHECKSUM_EN
  logic          err_checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int tpu_cnt = 0;
  int tpu_lat = 10;
  bit tpu_never = 1'b0;
  bit tpu_extra = 1'b0;
  logic [7:0] exp_bytes [128];

  typedef struct {
    int         nbytes;
    int         gap;
    int         lat;
    logic [3:0] num;
    bit         rnd;
    int         ovr;
    bit         never;
    int         exp_hi;
    bit         exp_rv;
    logic [3:0] exp_res;
    bit         exp_ovr;
  } vec_t;

  always #5 clk = ~clk;

  tpu_image_loader #(.TIMEOUT_CYCLES(TO), .TPU_MAX_CYCLES(WD)) dut (
    .clk(clk), .iRst_n(iRst_n), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .tpu_done(tpu_done), .tpu_num(tpu_num), .image_out(image_out), .tpu_ena(tpu_ena),
    .busy(busy), .result(result), .result_valid(result_valid), .err_timeout(err_timeout),
`ifdef TPU_IMG_CHECKSUM_EN
    .err_checksum(err_checksum),
`endif
    .err_overrun(err_overrun)
  );

  // Advance one clock, then play the TPU: done is raised tpu_lat cycles after enable.
  task automatic step();
    @(posedge clk);
    #1;
    if (tpu_ena) begin
      if (!tpu_never && tpu_cnt == tpu_lat) tpu_done = 1'b1;
      tpu_cnt++;
    end else begin
      tpu_done = tpu_extra;
      tpu_cnt  = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [1023:0] exp);
    int first;
    n_cmp++;
    if (image_out !== exp) begin
      n_bad++;
      first = 0;
      for (int k = 127; k >= 0; k--) if (image_out[8*k +: 8] !== exp[8*k +: 8]) first = k;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, first,
               image_out[8*first +: 8], exp[8*first +: 8]);
    end
  endtask

  function automatic logic [1023:0] img_of(input int n);
    logic [1023:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = exp_bytes[k];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  // Sends n bytes (plus the XOR byte for a full image when checksums are enabled).
  task automatic send_image(input int n, input int gap, input bit rnd, input bit bad_csum);
    logic [7:0] x;
    x = 8'd0;
    for (int k = 0; k < n; k++) exp_bytes[k] = rnd ? 8'($urandom) : 8'(k + 1);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) chk("ena_early", tpu_ena, 0);
      send_byte(exp_bytes[k]);
      x = x ^ exp_bytes[k];
      if (k == 0) begin
        chk("start_busy", busy, 1);
        chk("start_ovr_clr", err_overrun, 0);
        chk("start_rv_clr", result_valid, 0);
      end
      if (k < n - 1) repeat (gap) step();
    end
`ifdef TPU_IMG_CHECKSUM_EN
    if (n == 128) begin
      repeat (gap) step();
      chk("ena_before_csum", tpu_ena, 0);
      send_byte(bad_csum ? ~x : x);
    end
`else
    if (bad_csum) x = ~x;
`endif
  endtask

  task automatic run_case(input vec_t v);
    int hi;
    int n;
    bit ena_seen;
    tpu_lat   = v.lat;
    tpu_never = v.never;
    tpu_num   = v.num;
    send_image(v.nbytes, v.gap, v.rnd, 1'b0);
    if (v.nbytes == 128) begin
      chk("ena_rise", tpu_ena, 1);
      chk("run_busy", busy, 1);
`ifdef TPU_IMG_CHECKSUM_EN
      chk("csum_ok", err_checksum, 0);
`endif
      chk_img("image_full", img_of(128));
      hi = 1;
      for (int i = 0; i < 2000; i++) begin
        if ((i % 2 == 1) && (i < 2 * v.ovr)) begin
          rx_valid = 1'b1;
          rx_data  = 8'($urandom);
        end else begin
          rx_valid = 1'b0;
        end
        step();
        if (!tpu_ena) break;
        hi++;
      end
      rx_valid = 1'b0;
      chk("ena_high_len", hi, v.exp_hi);
      chk("wd_timeout", err_timeout, v.never);
      chk("busy_after", busy, 0);
      chk_img("image_kept", img_of(128));
    end else begin
      n = 0;
      ena_seen = 1'b0;
      for (int i = 0; i < 3 * TO; i++) begin
        step();
        n++;
        if (tpu_ena) ena_seen = 1'b1;
        if (err_timeout) break;
      end
      chk("gap_len", n, TO);
      chk("no_ena", ena_seen, 0);
      chk("busy_idle", busy, 0);
      chk_img("image_partial", img_of(v.nbytes));
    end
    chk("result_valid", result_valid, v.exp_rv);
    chk("result", result, v.exp_res);
    chk("overrun", err_overrun, v.exp_ovr);
    step();
    chk("timeout_pulse_end", err_timeout, 0);
    step();
  endtask

  vec_t vecs [5];

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    vecs[0] = '{128,  3, 50, 4'd7,  1'b0, 0, 1'b0, 51,  1'b1, 4'd7,  1'b0};
    vecs[1] = '{60,   1, 10, 4'd0,  1'b1, 0, 1'b0, 0,   1'b0, 4'd7,  1'b0};
    vecs[2] = '{128,  0, 30, 4'd3,  1'b1, 2, 1'b0, 31,  1'b1, 4'd3,  1'b1};
    vecs[3] = '{128,  1, 10, 4'd0,  1'b1, 0, 1'b1, WD,  1'b0, 4'd3,  1'b0};
    vecs[4] = '{128, 99, 12, 4'd15, 1'b1, 0, 1'b0, 13,  1'b1, 4'd15, 1'b0};

    repeat (2) step();
    chk("rst_image", (image_out == '0) ? 32'd1 : 32'd0, 1);
    chk("rst_outs", {tpu_ena, busy, result_valid, err_timeout, err_overrun, result}, 0);
    iRst_n = 1'b1;
    step();

    // First row: image_out[7:0]=0x01 and [1023:1016]=0x80 for the counting pattern.
    for (int r = 0; r < 5; r++) begin
      run_case(vecs[r]);
      if (r == 0) begin
        chk("img_lo", image_out[7:0], 8'h01);
        chk("img_hi", image_out[1023:1016], 8'h80);
      end
    end

    // tpu_done outside RUN has no effect.
    tpu_extra = 1'b1;
    tpu_num   = 4'd4;
    repeat (5) step();
    chk("done_ignored_res", result, 15);
    chk("done_ignored_rv", result_valid, 1);
    chk("done_ignored_ena", tpu_ena, 0);
    tpu_extra = 1'b0;
    step();

    // Random images against the byte-array reference.
    for (int r = 0; r < 3; r++) begin
      rv.nbytes = 128;
      rv.gap    = int'($urandom_range(0, 3));
      rv.lat    = int'($urandom_range(6, 40));
      rv.num    = 4'($urandom);
      rv.rnd    = 1'b1;
      rv.ovr    = int'($urandom_range(0, 2));
      rv.never  = 1'b0;
      rv.exp_hi = rv.lat + 1;
      rv.exp_rv = 1'b1;
      rv.exp_res = rv.num;
      rv.exp_ovr = (rv.ovr > 0);
      run_case(rv);
    end
    tpu_num = 4'd9;
    rv = '{128, 0, 8, 4'd9, 1'b1, 0, 1'b0, 9, 1'b1, 4'd9, 1'b0};
    run_case(rv);

    // clear coincident with byte 90: byte dropped, image wiped, result kept.
    for (int k = 0; k < 90; k++) send_byte(8'(k + 200));
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    clear    = 1'b1;
    step();
    rx_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_image", (image_out == '0) ? 32'd1 : 32'd0, 1);
    chk("clr_busy", busy, 0);
    chk("clr_ena", tpu_ena, 0);
    chk("clr_rv", result_valid, 0);
    chk("clr_result_kept", result, 9);
    repeat (3) step();
    chk("clr_stays_idle", busy, 0);
    rv = '{128, 0, 7, 4'd5, 1'b1, 0, 1'b0, 8, 1'b1, 4'd5, 1'b0};
    run_case(rv);

    // Asynchronous reset while in RUN with an overrun flagged.
    tpu_never = 1'b1;
    send_image(128, 0, 1'b1, 1'b0);
    chk("rst_pre_ena", tpu_ena, 1);
    send_byte(8'h5A);
    step();
    chk("rst_pre_ovr", err_overrun, 1);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("arst_image", (image_out == '0) ? 32'd1 : 32'd0, 1);
    chk("arst_outs", {tpu_ena, busy, result_valid, err_timeout, err_overrun, result}, 0);
    step();
    iRst_n    = 1'b1;
    tpu_never = 1'b0;
    step();

`ifdef TPU_IMG_CHECKSUM_EN
    // Corrupted checksum: single err_checksum pulse, TPU never enabled.
    send_image(128, 0, 1'b1, 1'b1);
    chk("csum_bad_pulse", err_checksum, 1);
    chk("csum_bad_ena", tpu_ena, 0);
    chk("csum_bad_busy", busy, 0);
    chk("csum_bad_rv", result_valid, 0);
    step();
    chk("csum_pulse_end", err_checksum, 0);
    chk("csum_bad_ena2", tpu_ena, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
